// File: rtl/vec_play.sv
// Phase-accumulator player for a 256-bit vector; outputs update 1 clk after the phase step.
// Define VEC_PLAY_SNAPSHOT_EN for a tear-free pass that plays from a snapshot refreshed only at LOAD and wrap.
module vec_play #(
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [255:0]       vec,
  input  logic               gate,
  input  logic [PHASE_W-1:0] step,
  output logic               bit_out,
  output logic [7:0]         idx,
  output logic [4:0]         level,
  output logic               adv,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [15:0]        history;

  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] phase_n;
  logic               carry;
  logic [7:0]         idx_n;
  logic               advance;
  logic               new_bit;
  logic [4:0]         level_n;

  assign sum     = {1'b0, phase} + {1'b0, step};
  assign phase_n = sum[PHASE_W-1:0];
  assign carry   = sum[PHASE_W];
  assign idx_n   = phase_n[PHASE_W-1 -: 8];
  assign advance = (idx_n != phase[PHASE_W-1 -: 8]);
  // level tracks popcount(history) incrementally: one bit in, the oldest out
  assign level_n = level + {4'b0, new_bit} - {4'b0, history[15]};

`ifdef VEC_PLAY_SNAPSHOT_EN
  logic [255:0] snapshot;

  // On a wrap the fresh vector is played immediately, not the stale snapshot
  assign new_bit = carry ? vec[idx_n] : snapshot[idx_n];

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
    end else if (state == LOAD) begin
      snapshot <= vec;
    end else if (state == RUN && gate && carry) begin
      snapshot <= vec;
    end
  end
`else
  assign new_bit = vec[idx_n];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      idx     <= '0;
      bit_out <= 1'b0;
      level   <= '0;
      history <= '0;
      adv     <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      adv  <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (gate) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          phase   <= '0;
          idx     <= '0;
          bit_out <= vec[0];
          history <= {15'b0, vec[0]};
          level   <= {4'b0, vec[0]};
          state   <= RUN;
        end
        RUN: begin
          if (!gate) begin
            state   <= IDLE;
            busy    <= 1'b0;
            phase   <= '0;
            idx     <= '0;
            bit_out <= 1'b0;
            history <= '0;
            level   <= '0;
          end else begin
            phase <= phase_n;
            wrap  <= carry;
            // Skipped indices never reach history; only the landing index is played
            if (advance) begin
              idx     <= idx_n;
              bit_out <= new_bit;
              history <= {history[14:0], new_bit};
              level   <= level_n;
              adv     <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
